// File: rtl/seg_pkg.sv
// Shared types and segment constants for the display scheduler.
// Holds the FSM state enum, the 2-bit code type and segment patterns.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B,
        GAP
    } state_t;

    typedef logic [1:0] code_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ZERO  = 8'h3F;
    localparam logic [7:0] SEG_ONE   = 8'h06;
    localparam logic [7:0] SEG_TWO   = 8'h5B;

endpackage

// File: rtl/seg_scheduler_if.sv
// Requester/display bundle between the two requesters and the scheduler.
// master: drives req_a/val_a/req_b/val_b; slave: drives gnt_a/gnt_b/busy/SEG.
import seg_pkg::*;

interface seg_scheduler_if;
    logic        req_a;
    code_t       val_a;
    logic        req_b;
    code_t       val_b;
    logic        gnt_a;
    logic        gnt_b;
    logic        busy;
    logic [7:0]  SEG;

    modport master (
        output req_a, val_a, req_b, val_b,
        input  gnt_a, gnt_b, busy, SEG
    );

    modport slave (
        input  req_a, val_a, req_b, val_b,
        output gnt_a, gnt_b, busy, SEG
    );
endinterface

// File: rtl/seg_decoder.sv
// Combinational 2-bit code to 7-segment pattern (bit 0 = a, bit 7 = dp).
// Ports: code (in, 2 bits), pattern (out, 8 bits).
import seg_pkg::*;

module seg_decoder (
    input  code_t      code,
    output logic [7:0] pattern
);
    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            2'b00:   pattern = SEG_BLANK;
            2'b01:   pattern = SEG_ZERO;
            2'b10:   pattern = SEG_ONE;
            2'b11:   pattern = SEG_TWO;
            default: pattern = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg_scheduler.sv
// Round-robin owner of a shared 7-segment display for requesters A and B.
// Ports: clk_2, reset (sync, active-high), bus (seg_scheduler_if.slave).
// Macro SEG_OWNER_DP_EN: when defined, SEG[7] lights while B owns.
import seg_pkg::*;

module seg_scheduler #(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic            clk_2,
    input  logic            reset,
    seg_scheduler_if.slave  bus
);
    localparam logic [3:0] DWELL_LD = 4'(DWELL - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       prio_a, prio_a_nx;
    code_t      code, code_nx;
    logic [7:0] pat;
    logic [7:0] seg_nx;
    logic       own_nx;

    // prio_a = 1 means A wins a tie; it flips to the other side on grant.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        prio_a_nx = prio_a;
        code_nx   = code;
        unique case (state)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || prio_a)) begin
                    state_nx  = OWN_A;
                    cnt_nx    = DWELL_LD;
                    code_nx   = bus.val_a;
                    prio_a_nx = 1'b0;
                end else if (bus.req_b) begin
                    state_nx  = OWN_B;
                    cnt_nx    = DWELL_LD;
                    code_nx   = bus.val_b;
                    prio_a_nx = 1'b1;
                end
            end
            OWN_A: begin
                if (cnt == 4'd0 || !bus.req_a) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            OWN_B: begin
                if (cnt == 4'd0 || !bus.req_b) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            GAP: begin
                if (cnt == 4'd0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Decode the code that will be held in the next state, so the
    // registered SEG lines up with the registered grant.
    seg_decoder u_dec (
        .code    (code_nx),
        .pattern (pat)
    );

    always_comb begin
        own_nx = (state_nx == OWN_A) || (state_nx == OWN_B);
        seg_nx = own_nx ? pat : SEG_BLANK;
`ifdef SEG_OWNER_DP_EN
        seg_nx[7] = (state_nx == OWN_B);
`else
        seg_nx[7] = 1'b0;
`endif
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            prio_a    <= 1'b1;
            code      <= 2'b00;
            bus.gnt_a <= 1'b0;
            bus.gnt_b <= 1'b0;
            bus.busy  <= 1'b0;
            bus.SEG   <= SEG_BLANK;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            prio_a    <= prio_a_nx;
            code      <= code_nx;
            bus.gnt_a <= (state_nx == OWN_A);
            bus.gnt_b <= (state_nx == OWN_B);
            bus.busy  <= (state_nx != IDLE);
            bus.SEG   <= seg_nx;
        end
    end
endmodule

// File: tb/tb_seg_scheduler.sv
// Directed bench for seg_scheduler (DWELL=4, GAP_CYC=1).
// Status word checked per cycle: {gnt_a, gnt_b, busy, SEG}.
import seg_pkg::*;

module tb_seg_scheduler;
    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

`ifdef SEG_OWNER_DP_EN
    localparam logic [7:0] DP_B = 8'h80;
`else
    localparam logic [7:0] DP_B = 8'h00;
`endif

    seg_scheduler_if bus ();

    seg_scheduler #(
        .DWELL   (4),
        .GAP_CYC (1)
    ) dut (
        .clk_2 (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] st(input logic ga, input logic gb,
                                       input logic bz,
                                       input logic [7:0] sg);
        return {5'b0, ga, gb, bz, sg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge, then check status and grant exclusivity.
    task automatic step(input string tag, input logic [15:0] exp);
        tick();
        chk(tag, {5'b0, bus.gnt_a, bus.gnt_b, bus.busy, bus.SEG}, exp);
        chk({tag, "_excl"}, {15'b0, bus.gnt_a & bus.gnt_b}, 16'h0);
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.req_a = 1'b0;
        bus.val_a = 2'b00;
        bus.req_b = 1'b0;
        bus.val_b = 2'b00;

        // Reset then idle
        tick();
        step("rst", st(0, 0, 0, 8'h00));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("idle", st(0, 0, 0, 8'h00));

        // Single requester, val change during ownership is ignored
        bus.req_a = 1'b1;
        bus.val_a = 2'b11;
        step("sa1", st(1, 0, 1, 8'h5B));
        step("sa2", st(1, 0, 1, 8'h5B));
        bus.val_a = 2'b01;
        step("sa3", st(1, 0, 1, 8'h5B));
        step("sa4", st(1, 0, 1, 8'h5B));
        step("sa_gap", st(0, 0, 1, 8'h00));
        step("sa_idle", st(0, 0, 0, 8'h00));
        step("sa_regnt", st(1, 0, 1, 8'h3F));
        bus.req_a = 1'b0;
        step("sa_rel", st(0, 0, 1, 8'h00));
        step("sa_end", st(0, 0, 0, 8'h00));

        // Contention, round-robin from a fresh pointer
        reset = 1'b1;
        step("c_rst", st(0, 0, 0, 8'h00));
        reset     = 1'b0;
        bus.req_a = 1'b1;
        bus.val_a = 2'b01;
        bus.req_b = 1'b1;
        bus.val_b = 2'b10;
        for (int i = 0; i < 4; i++) step("c_a", st(1, 0, 1, 8'h3F));
        step("c_gap1", st(0, 0, 1, 8'h00));
        step("c_idle1", st(0, 0, 0, 8'h00));
        for (int i = 0; i < 4; i++) step("c_b", st(0, 1, 1, 8'h06 | DP_B));
        step("c_gap2", st(0, 0, 1, 8'h00));
        step("c_idle2", st(0, 0, 0, 8'h00));
        step("c_a2", st(1, 0, 1, 8'h3F));

        // Early release of B, val_b changes never shown
        reset = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        step("e_rst", st(0, 0, 0, 8'h00));
        reset     = 1'b0;
        bus.req_b = 1'b1;
        bus.val_b = 2'b01;
        step("e_b1", st(0, 1, 1, 8'h3F | DP_B));
        bus.val_b = 2'b10;
        step("e_b2", st(0, 1, 1, 8'h3F | DP_B));
        bus.req_b = 1'b0;
        bus.val_b = 2'b11;
        step("e_gap", st(0, 0, 1, 8'h00));
        step("e_idle", st(0, 0, 0, 8'h00));

        // Reset in 3rd cycle of OWN_A, pointer returns to A
        bus.req_a = 1'b1;
        bus.val_a = 2'b11;
        step("r_a1", st(1, 0, 1, 8'h5B));
        step("r_a2", st(1, 0, 1, 8'h5B));
        step("r_a3", st(1, 0, 1, 8'h5B));
        reset     = 1'b1;
        bus.req_b = 1'b1;
        bus.val_b = 2'b10;
        step("r_abort", st(0, 0, 0, 8'h00));
        reset = 1'b0;
        step("r_ptr", st(1, 0, 1, 8'h5B));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
